// File: rtl/countdown_drain_if.sv
// -----------------------------------------------------------------------------
// countdown_drain_if
//
// Groups the load request, the drain handshake and the observable counters of
// the countdown drain block into one bundle.
//
// Signals (named from the drain block's point of view):
//   load       request to load load_val (honoured only in IDLE or DONE)
//   load_val   requested token count, unsigned, WIDTH bits
//   selector   drain enable; a token is only taken while this is high
//   out_ready  downstream consumer accepts a token
//   out_valid  token offered (drain block is in DRAIN)
//   sn         remaining token count
//   i          drain index, always sn + 1
//   done       drain block is in DONE
//   clamped    last accepted load exceeded LIMIT
//
// Modports:
//   master  the side that issues loads and consumes tokens (bench / consumer)
//   slave   the countdown drain block itself
// -----------------------------------------------------------------------------
interface countdown_drain_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             selector;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] sn;
  logic [WIDTH-1:0] i;
  logic             done;
  logic             clamped;

  modport master (
    output load,
    output load_val,
    output selector,
    output out_ready,
    input  out_valid,
    input  sn,
    input  i,
    input  done,
    input  clamped
  );

  modport slave (
    input  load,
    input  load_val,
    input  selector,
    input  out_ready,
    output out_valid,
    output sn,
    output i,
    output done,
    output clamped
  );

endinterface

// File: rtl/countdown_drain.sv
// -----------------------------------------------------------------------------
// countdown_drain
//
// Drain-side counterpart of the up-counting sn/i accumulator. A count (clamped
// to LIMIT) is loaded, then one token is handed downstream per accepted
// handshake until the count reaches zero. The pair sn / i is kept so that
// i == sn + 1 holds on every cycle, mirroring the accumulator's relation.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset
//   bus   countdown_drain_if.slave
//           load, load_val, selector, out_ready  (inputs)
//           out_valid, sn, i, done, clamped      (outputs)
//
// Parameters:
//   WIDTH  width of sn, i and load_val
//   LIMIT  largest loadable count; LIMIT + 1 must fit in WIDTH bits
// -----------------------------------------------------------------------------
module countdown_drain #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 70
) (
  input  logic                  clk,
  input  logic                  rst,
  countdown_drain_if.slave      bus
);

  // The encoding 2'b11 is deliberately left unused; the next-state logic
  // steers it back to IDLE with a clean count.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);
  localparam logic [WIDTH-1:0] Zero     = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sn_q, sn_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             clamped_q, clamped_d;

  logic             isOverLimit;
  logic [WIDTH-1:0] clampedVal;
  logic             offerValid;
  logic             takeStep;

  // Clamp the requested count to LIMIT. This is evaluated every cycle but only
  // used when a load is actually honoured.
  always_comb begin
    isOverLimit = (bus.load_val > LimitVal);
    clampedVal  = isOverLimit ? LimitVal : bus.load_val;
  end

  // A token moves only while an offer is standing and both the consumer and
  // the drain enable agree. Outside DRAIN the offer is low, so out_ready and
  // selector cannot disturb the count in IDLE or DONE.
  always_comb begin
    offerValid = (state_q == DRAIN);
    takeStep   = offerValid && bus.out_ready && bus.selector;
  end

  // Next-state and next-count logic. Everything holds by default; a load is
  // only considered outside DRAIN and a step only inside DRAIN, so the two can
  // never collide. The last token (sn == 1) moves straight to DONE, leaving
  // sn = 0 and i = 1 behind.
  always_comb begin
    state_d   = state_q;
    sn_d      = sn_q;
    idx_d     = idx_q;
    clamped_d = clamped_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.load) begin
          sn_d      = clampedVal;
          idx_d     = clampedVal + One;
          clamped_d = isOverLimit;
          state_d   = (clampedVal != Zero) ? DRAIN : DONE;
        end
      end

      DRAIN: begin
        if (takeStep) begin
          sn_d  = sn_q - One;
          idx_d = idx_q - One;
          if (sn_q == One) begin
            state_d = DONE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sn_d    = Zero;
        idx_d   = One;
      end
    endcase
  end

  // State and count registers. Reset wins over any load or step presented in
  // the same cycle, including a reset that lands in the middle of a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sn_q      <= Zero;
      idx_q     <= One;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sn_q      <= sn_d;
      idx_q     <= idx_d;
      clamped_q <= clamped_d;
    end
  end

  // Status outputs are straight decodes of the state register, so done and
  // out_valid follow reset one cycle later along with the counters.
  always_comb begin
    bus.out_valid = offerValid;
    bus.done      = (state_q == DONE);
    bus.sn        = sn_q;
    bus.i         = idx_q;
    bus.clamped   = clamped_q;
  end

endmodule
